call_register: RTL

CALL_REGISTER -- requirements
Module: call_register

---
 rtl/elevator_pkg.sv | 14 +
 rtl/btn_debounce.sv | 36 +++
 rtl/call_register.sv | 101 ++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared defaults and request kinds for the elevator call register.
package elevator_pkg;

  localparam int FLOORS_DEFAULT   = 8;
  localparam int FLOOR_W_DEFAULT  = 3;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    REQ_IN   = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DOWN = 2'd2
  } req_kind_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus saturating high-sample counter; emits a single
// registered accept pulse per continuous press.
module btn_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Counter saturates at DEBOUNCE, so a held button cannot fire again until a low sample re-arms it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      accept <= sync2 && (cnt == CW'(DEBOUNCE - 1));
      if (!sync2)
        cnt <= '0;
      else if (cnt != CW'(DEBOUNCE))
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/call_register.sv
// Latches debounced car and hall calls, applies lockouts and service clears,
// and publishes registered above/here/below summaries and a request count.
module call_register
  import elevator_pkg::*;
#(
  parameter int FLOORS   = FLOORS_DEFAULT,
  parameter int FLOOR_W  = FLOOR_W_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-1:0]  btn_up_out,
  input  logic [FLOORS-1:0]  btn_down_out,
  input  logic [FLOORS-1:0]  block_mask,
  input  logic [FLOORS-1:0]  inactivate_in_levels,
  input  logic [FLOORS-1:0]  inactivate_out_up_levels,
  input  logic [FLOORS-1:0]  inactivate_out_down_levels,
  input  logic [FLOOR_W-1:0] cur_floor,
  output logic [FLOORS-1:0]  active_in_levels,
  output logic [FLOORS-1:0]  active_out_up_levels,
  output logic [FLOORS-1:0]  active_out_down_levels,
  output logic               any_above,
  output logic               any_here,
  output logic               any_below,
  output logic [FLOOR_W:0]   req_count
);

  // No "up" call exists at the top floor and no "down" call at the bottom floor.
  localparam logic [FLOORS-1:0] UP_OK   = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0]  raw [3];
  logic [FLOORS-1:0]  acc [3];
  logic [FLOORS-1:0]  any_req;
  logic               above_c;
  logic               here_c;
  logic               below_c;
  logic [FLOOR_W:0]   count_c;

  assign raw[int'(REQ_IN)]   = btn_in;
  assign raw[int'(REQ_UP)]   = btn_up_out;
  assign raw[int'(REQ_DOWN)] = btn_down_out;

  for (genvar k = 0; k < 3; k++) begin : g_kind
    for (genvar f = 0; f < FLOORS; f++) begin : g_floor
      btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw[k][f]),
        .accept (acc[k][f])
      );
    end
  end

  assign any_req = active_in_levels | active_out_up_levels | active_out_down_levels;

  // A cur_floor beyond the last served floor is above every index, so all requests fall into "below".
  always_comb begin
    above_c = 1'b0;
    here_c  = 1'b0;
    below_c = 1'b0;
    count_c = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (any_req[f]) begin
        count_c = count_c + (FLOOR_W+1)'(1);
        if (FLOOR_W'(f) > cur_floor)
          above_c = 1'b1;
        else if (FLOOR_W'(f) == cur_floor)
          here_c = 1'b1;
        else
          below_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_in_levels       <= '0;
      active_out_up_levels   <= '0;
      active_out_down_levels <= '0;
      any_above              <= 1'b0;
      any_here               <= 1'b0;
      any_below              <= 1'b0;
      req_count              <= '0;
    end else begin
      // Clear is applied last so it wins over a coincident accept.
      active_in_levels <= (active_in_levels | (acc[int'(REQ_IN)] & ~block_mask))
                          & ~inactivate_in_levels;
      active_out_up_levels <= (active_out_up_levels | (acc[int'(REQ_UP)] & UP_OK))
                              & ~inactivate_out_up_levels;
      active_out_down_levels <= (active_out_down_levels | (acc[int'(REQ_DOWN)] & DOWN_OK))
                                & ~inactivate_out_down_levels;
      any_above <= above_c;
      any_here  <= here_c;
      any_below <= below_c;
      req_count <= count_c;
    end
  end

endmodule
